// File: rtl/rs_age_ordered.sv
// rs_age_ordered: age-ordered reservation station feeding one ALU.
// Entries wait for both operands and snoop NUM_CDB result buses.
// The oldest ready entry, by ROB distance from rob_head, issues
// through a registered valid/ready stage.
// Optional feature: define RS_DISPATCH_BYPASS_EN to capture a CDB broadcast
// that arrives in the same cycle as the dispatch of a waiting operand.
module rs_age_ordered #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2,
  parameter int XLEN    = 32,
  parameter int ROB_W   = 3,
  parameter int OP_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall,
  input  logic                       disp_valid,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [ROB_W-1:0]           disp_id,
  input  logic                       disp_rdy1,
  input  logic [ROB_W-1:0]           disp_q1,
  input  logic [XLEN-1:0]            disp_v1,
  input  logic                       disp_rdy2,
  input  logic [ROB_W-1:0]           disp_q2,
  input  logic [XLEN-1:0]            disp_v2,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]   cdb_id,
  input  logic [NUM_CDB*XLEN-1:0]    cdb_val,
  input  logic [ROB_W-1:0]           rob_head,
  output logic                       rs_full,
  output logic [$clog2(DEPTH+1)-1:0] rs_count,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [OP_W-1:0]            iss_op,
  output logic [XLEN-1:0]            iss_v1,
  output logic [XLEN-1:0]            iss_v2,
  output logic [ROB_W-1:0]           iss_id
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  // Entry storage
  logic             r_busy [DEPTH];
  logic [OP_W-1:0]  r_op   [DEPTH];
  logic [ROB_W-1:0] r_id   [DEPTH];
  logic             r_rdy1 [DEPTH];
  logic [ROB_W-1:0] r_q1   [DEPTH];
  logic [XLEN-1:0]  r_v1   [DEPTH];
  logic             r_rdy2 [DEPTH];
  logic [ROB_W-1:0] r_q2   [DEPTH];
  logic [XLEN-1:0]  r_v2   [DEPTH];

  logic [CW-1:0]    r_count;
  logic             r_iss_valid;
  logic [OP_W-1:0]  r_iss_op;
  logic [XLEN-1:0]  r_iss_v1;
  logic [XLEN-1:0]  r_iss_v2;
  logic [ROB_W-1:0] r_iss_id;

  logic             w_full;
  logic             w_disp_acc;
  logic             w_free_found;
  logic [IW-1:0]    w_free_idx;
  logic             w_sel_found;
  logic [IW-1:0]    w_sel_idx;
  logic [ROB_W-1:0] w_sel_age;
  logic [ROB_W-1:0] w_age;
  logic             w_iss_load;
  logic             w_h1   [DEPTH];
  logic [XLEN-1:0]  w_hv1  [DEPTH];
  logic             w_h2   [DEPTH];
  logic [XLEN-1:0]  w_hv2  [DEPTH];
  logic             w_d_rdy1;
  logic [XLEN-1:0]  w_d_v1;
  logic             w_d_rdy2;
  logic [XLEN-1:0]  w_d_v2;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_disp_acc = disp_valid & ~w_full & ~stall;
  assign w_iss_load = (~r_iss_valid | iss_ready) & w_sel_found;

  // Lowest free slot, based on occupancy at cycle start
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!r_busy[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
  end

  // Oldest eligible entry; age is ROB distance from the head
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_age   = '0;
    w_age       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_age = r_id[i] - rob_head;
      if (r_busy[i] && r_rdy1[i] && r_rdy2[i] &&
          (!w_sel_found || (w_age < w_sel_age))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IW'(i);
        w_sel_age   = w_age;
      end
    end
  end

  // CDB tag match per entry operand; the first match from bus 0 upward wins
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_h1[i]  = 1'b0;
      w_hv1[i] = '0;
      w_h2[i]  = 1'b0;
      w_hv2[i] = '0;
      for (int unsigned k = 0; k < NUM_CDB; k++) begin
        if (cdb_valid[k] && !w_h1[i] && (cdb_id[k*ROB_W +: ROB_W] == r_q1[i])) begin
          w_h1[i]  = 1'b1;
          w_hv1[i] = cdb_val[k*XLEN +: XLEN];
        end
        if (cdb_valid[k] && !w_h2[i] && (cdb_id[k*ROB_W +: ROB_W] == r_q2[i])) begin
          w_h2[i]  = 1'b1;
          w_hv2[i] = cdb_val[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Operand state written on dispatch, optionally merged with a same-cycle CDB
  always_comb begin
    w_d_rdy1 = disp_rdy1;
    w_d_v1   = disp_v1;
    w_d_rdy2 = disp_rdy2;
    w_d_v2   = disp_v2;
`ifdef RS_DISPATCH_BYPASS_EN
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (!w_d_rdy1 && cdb_valid[k] && (cdb_id[k*ROB_W +: ROB_W] == disp_q1)) begin
        w_d_rdy1 = 1'b1;
        w_d_v1   = cdb_val[k*XLEN +: XLEN];
      end
      if (!w_d_rdy2 && cdb_valid[k] && (cdb_id[k*ROB_W +: ROB_W] == disp_q2)) begin
        w_d_rdy2 = 1'b1;
        w_d_v2   = cdb_val[k*XLEN +: XLEN];
      end
    end
`endif
  end

  // Entry update: wakeup, then free on select, then insert on dispatch
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_busy[i] <= 1'b0;
        r_op[i]   <= '0;
        r_id[i]   <= '0;
        r_rdy1[i] <= 1'b0;
        r_q1[i]   <= '0;
        r_v1[i]   <= '0;
        r_rdy2[i] <= 1'b0;
        r_q2[i]   <= '0;
        r_v2[i]   <= '0;
      end
      r_count     <= '0;
      r_iss_valid <= 1'b0;
      r_iss_op    <= '0;
      r_iss_v1    <= '0;
      r_iss_v2    <= '0;
      r_iss_id    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_busy[i] && !r_rdy1[i] && w_h1[i]) begin
          r_rdy1[i] <= 1'b1;
          r_v1[i]   <= w_hv1[i];
        end
        if (r_busy[i] && !r_rdy2[i] && w_h2[i]) begin
          r_rdy2[i] <= 1'b1;
          r_v2[i]   <= w_hv2[i];
        end
      end
      if (w_iss_load) begin
        r_busy[w_sel_idx] <= 1'b0;
      end
      // The free slot is never busy, so it cannot collide with the selected slot
      if (w_disp_acc) begin
        r_busy[w_free_idx] <= 1'b1;
        r_op[w_free_idx]   <= disp_op;
        r_id[w_free_idx]   <= disp_id;
        r_rdy1[w_free_idx] <= w_d_rdy1;
        r_q1[w_free_idx]   <= disp_q1;
        r_v1[w_free_idx]   <= w_d_v1;
        r_rdy2[w_free_idx] <= w_d_rdy2;
        r_q2[w_free_idx]   <= disp_q2;
        r_v2[w_free_idx]   <= w_d_v2;
      end
      if (w_iss_load) begin
        r_iss_valid <= 1'b1;
        r_iss_op    <= r_op[w_sel_idx];
        r_iss_v1    <= r_v1[w_sel_idx];
        r_iss_v2    <= r_v2[w_sel_idx];
        r_iss_id    <= r_id[w_sel_idx];
      end else if (iss_ready) begin
        r_iss_valid <= 1'b0;
      end
      case ({w_disp_acc, w_iss_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rs_full   = w_full;
  assign rs_count  = r_count;
  assign iss_valid = r_iss_valid;
  assign iss_op    = r_iss_op;
  assign iss_v1    = r_iss_v1;
  assign iss_v2    = r_iss_v2;
  assign iss_id    = r_iss_id;

endmodule
